// File: rtl/noc_vc_input_route_buffer_if.sv
// noc_vc_input_route_buffer_if: flit type and valid/ready flit link with per-VC ready
package noc_flit_pkg;
  typedef struct packed {
    logic [3:0]  vc;
    logic        head;
    logic        tail;
    logic [3:0]  dest_x;
    logic [3:0]  dest_y;
    logic [15:0] data;
  } flit_t;
endpackage

interface Noc_flit_interface #(
  parameter int CHANNELS = 2
);
  import noc_flit_pkg::*;
  logic                valid;
  flit_t               flit;
  logic [CHANNELS-1:0] ready;
  logic [CHANNELS-1:0] vc_ready;
  modport sender (output valid, flit, input ready, vc_ready);
  modport receiver (input valid, flit, output ready, vc_ready);
endinterface

// File: rtl/noc_vc_input_route_buffer.sv
// noc_vc_input_route_buffer: per-VC flit FIFOs, XY routing with wormhole hold, round-robin VC select
module noc_vc_input_route_buffer #(
  parameter int CHANNELS = 2,
  parameter int ENTRIES  = 5,
  parameter int DEPTH    = 4,
  parameter int MY_X     = 0,
  parameter int MY_Y     = 0
) (
  input  logic                i_clk,
  input  logic                i_rst,
  Noc_flit_interface.receiver receiver_if,
  Noc_flit_interface.sender   sender_if,
  output logic [ENTRIES-1:0]  o_select
);
  import noc_flit_pkg::*;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
  flit_t               mem_q [CHANNELS][DEPTH];
  flit_t               mem_d [CHANNELS][DEPTH];
  flit_t               front [CHANNELS];
  logic [PW-1:0]       wr_q [CHANNELS], wr_d [CHANNELS], rd_q [CHANNELS], rd_d [CHANNELS];
  logic [PW:0]         cnt_q [CHANNELS], cnt_d [CHANNELS];
  logic [ENTRIES-1:0]  route_q [CHANNELS], route_d [CHANNELS], xy [CHANNELS], cand [CHANNELS];
  logic [CHANNELS-1:0] active_q, active_d, elig, full, push, pop;
  logic [CW-1:0]       rr_q, rr_d, gnt;
  logic                found;
  logic                unused_vc_ready;

  assign unused_vc_ready = ^sender_if.vc_ready;

  function automatic logic [ENTRIES-1:0] xy_route(flit_t f);
    return int'(f.dest_x) > MY_X ? ENTRIES'(4) :
           int'(f.dest_x) < MY_X ? ENTRIES'(16) :
           int'(f.dest_y) > MY_Y ? ENTRIES'(2) :
           int'(f.dest_y) < MY_Y ? ENTRIES'(8) : ENTRIES'(1);
  endfunction

  // Status flags, candidate routes and round-robin pick from (last grant + 1)
  always_comb begin
    found = 1'b0;
    gnt = rr_q;
    for (int c = 0; c < CHANNELS; c++) begin
      front[c] = mem_q[c][rd_q[c]];
      xy[c] = xy_route(front[c]);
      cand[c] = front[c].head ? xy[c] : route_q[c];
      full[c] = cnt_q[c] == (PW+1)'(DEPTH);
      elig[c] = cnt_q[c] != '0 && sender_if.ready[c];
      receiver_if.ready[c] = !full[c];
      receiver_if.vc_ready[c] = cnt_q[c] == '0 && !active_q[c];
    end
    for (int i = 1; i <= CHANNELS; i++)
      if (!found && elig[CW'((int'(rr_q) + i) % CHANNELS)]) begin
        found = 1'b1;
        gnt = CW'((int'(rr_q) + i) % CHANNELS);
      end
    for (int c = 0; c < CHANNELS; c++) begin
      pop[c] = found && int'(gnt) == c;
      push[c] = receiver_if.valid && int'(receiver_if.flit.vc) == c && (!full[c] || pop[c]);
    end
    sender_if.valid = found;
    sender_if.flit = front[gnt];
    o_select = found ? cand[gnt] : '0;
  end

  // FIFO pointer/count updates and per-VC wormhole route tracking
  always_comb begin
    mem_d = mem_q;
    rr_d = found ? gnt : rr_q;
    for (int c = 0; c < CHANNELS; c++) begin
      if (push[c]) mem_d[c][wr_q[c]] = receiver_if.flit;
      wr_d[c] = wr_q[c] + PW'(push[c]);
      rd_d[c] = rd_q[c] + PW'(pop[c]);
      cnt_d[c] = cnt_q[c] + (PW+1)'(push[c]) - (PW+1)'(pop[c]);
      active_d[c] = pop[c] && front[c].tail ? 1'b0 : pop[c] && front[c].head ? 1'b1 : active_q[c];
      route_d[c] = pop[c] && front[c].head && !front[c].tail ? xy[c] : route_q[c];
    end
  end

  // Flit storage carries no reset; occupancy alone decides what is valid
  always_ff @(posedge i_clk)
    mem_q <= mem_d;

  // Control state with asynchronous reset discarding all buffered flits
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      wr_q <= '{default: '0};
      rd_q <= '{default: '0};
      cnt_q <= '{default: '0};
      route_q <= '{default: '0};
      active_q <= '0;
      rr_q <= CW'(CHANNELS - 1);
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      route_q <= route_d;
      active_q <= active_d;
      rr_q <= rr_d;
    end

  // A body or tail flit must never reach the front of a VC with no packet open
  always_ff @(posedge i_clk)
    for (int c = 0; c < CHANNELS; c++)
      assert (i_rst || cnt_q[c] == '0 || active_q[c] || front[c].head)
        else $error("non-head flit at front of idle VC %0d", c);
endmodule

// File: tb/tb_noc_vc_input_route_buffer.sv
// tb_noc_vc_input_route_buffer: directed tables, corner sequences and random traffic against a queue model
module tb_noc_vc_input_route_buffer;
  import noc_flit_pkg::*;
  localparam int CH = 2, EN = 5, DP = 4;
  logic clk = 0, rst = 0;
  logic [EN-1:0] sel;
  int checks = 0, failures = 0;
  Noc_flit_interface #(.CHANNELS(CH)) rx ();
  Noc_flit_interface #(.CHANNELS(CH)) tx ();
  noc_vc_input_route_buffer #(.CHANNELS(CH), .ENTRIES(EN), .DEPTH(DP), .MY_X(1), .MY_Y(1)) dut (
    .i_clk(clk), .i_rst(rst), .receiver_if(rx), .sender_if(tx), .o_select(sel));
  always #5 clk = ~clk;

  typedef struct {logic [3:0] dx; logic [3:0] dy; logic [EN-1:0] sel;} vec_t;
  vec_t tbl[5];
  flit_t mq[CH][$];
  bit in_pkt[CH];
  logic [EN-1:0] hold[CH];
  int last;
  int s_g;
  bit s_acc;
  logic [EN-1:0] s_sel;
  logic [CH-1:0] s_rdy, s_vrdy;
  int gl[CH];
  int rvc, rlen;
  bit rv;
  flit_t rf;

  function automatic logic [EN-1:0] xy(int dx, int dy);
    if (dx > 1) return 5'b00100;
    if (dx < 1) return 5'b10000;
    if (dy > 1) return 5'b00010;
    if (dy < 1) return 5'b01000;
    return 5'b00001;
  endfunction

  function automatic flit_t mk(int vc, bit h, bit t, int dx, int dy, int d);
    flit_t f;
    f.vc = 4'(vc);
    f.head = h;
    f.tail = t;
    f.dest_x = 4'(dx);
    f.dest_y = 4'(dy);
    f.data = 16'(d);
    return f;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      mq[c].delete();
      in_pkt[c] = 0;
      hold[c] = '0;
    end
    last = CH - 1;
  endtask

  task automatic do_reset();
    #2;
    rst = 1;
    rx.valid = 0;
    #1;
    check("rst_valid", 32'(tx.valid), 0);
    check("rst_select", 32'(sel), 0);
    check("rst_ready", 32'(rx.ready), 32'(2'b11));
    check("rst_vc_ready", 32'(rx.vc_ready), 32'(2'b11));
    @(negedge clk);
    rst = 0;
    model_reset();
  endtask

  task automatic cycle(input bit v, input flit_t f, input logic [CH-1:0] dr);
    int g;
    logic [EN-1:0] es;
    @(negedge clk);
    rx.valid = v;
    rx.flit = f;
    tx.ready = dr;
    #1;
    g = -1;
    for (int i = 1; i <= CH; i++) begin
      int k;
      k = (last + i) % CH;
      if (g < 0 && mq[k].size() > 0 && dr[k]) g = k;
    end
    es = g < 0 ? '0 : (mq[g][0].head ? xy(mq[g][0].dest_x, mq[g][0].dest_y) : hold[g]);
    for (int c = 0; c < CH; c++) begin
      check($sformatf("ready%0d", c), 32'(rx.ready[c]), 32'(mq[c].size() < DP));
      check($sformatf("vc_ready%0d", c), 32'(rx.vc_ready[c]), 32'(mq[c].size() == 0 && !in_pkt[c]));
    end
    check("valid", 32'(tx.valid), 32'(g >= 0));
    check("select", 32'(sel), 32'(es));
    if (g >= 0) check("flit", 32'(tx.flit), 32'(mq[g][0]));
    s_sel = sel;
    s_rdy = rx.ready;
    s_vrdy = rx.vc_ready;
    s_acc = v && int'(f.vc) < CH && (mq[f.vc].size() < DP || g == int'(f.vc));
    s_g = g;
    @(posedge clk);
    if (g >= 0) begin
      flit_t h;
      h = mq[g].pop_front();
      if (h.head && !h.tail) begin
        in_pkt[g] = 1;
        hold[g] = xy(h.dest_x, h.dest_y);
      end else if (h.tail) in_pkt[g] = 0;
      last = g;
    end
    if (s_acc) mq[f.vc].push_back(f);
  endtask

  initial begin
    tbl[0] = '{4'd2, 4'd1, 5'b00100};
    tbl[1] = '{4'd0, 4'd1, 5'b10000};
    tbl[2] = '{4'd1, 4'd2, 5'b00010};
    tbl[3] = '{4'd1, 4'd0, 5'b01000};
    tbl[4] = '{4'd1, 4'd1, 5'b00001};
    rx.valid = 0;
    rx.flit = '0;
    tx.ready = '1;
    tx.vc_ready = '1;
    for (int c = 0; c < CH; c++) gl[c] = 0;
    do_reset();

    for (int i = 0; i < 5; i++) begin
      cycle(1, mk(0, 1, 1, tbl[i].dx, tbl[i].dy, i), 2'b11);
      cycle(0, '0, 2'b11);
      check($sformatf("route_grant%0d", i), 32'(s_g), 0);
      check($sformatf("route_sel%0d", i), 32'(s_sel), 32'(tbl[i].sel));
    end

    cycle(1, mk(1, 1, 0, 3, 1, 100), 2'b11);
    cycle(1, mk(1, 0, 0, 0, 0, 101), 2'b11);
    for (int i = 0; i < 3; i++) begin
      cycle(i < 2, mk(1, 0, i == 1, 0, 0, 102 + i), 2'b11);
      check($sformatf("worm_sel%0d", i), 32'(s_sel), 32'(5'b00100));
      check($sformatf("worm_vc_ready%0d", i), 32'(s_vrdy[1]), 0);
    end
    cycle(0, '0, 2'b11);
    check("worm_vc_ready_end", 32'(s_vrdy[1]), 1);

    for (int i = 0; i < 4; i++) cycle(1, mk(0, 1, 1, 2, 2, 200 + i), 2'b10);
    cycle(1, mk(0, 1, 1, 0, 0, 204), 2'b11);
    check("full_ready", 32'(s_rdy[0]), 0);
    check("full_pushpop_acc", 32'(s_acc), 1);
    check("full_pushpop_grant", 32'(s_g), 0);
    for (int i = 0; i < 5; i++) begin
      cycle(0, '0, 2'b11);
      check($sformatf("drain_ready%0d", i), 32'(s_rdy[0]), 32'(i > 0));
      check($sformatf("drain_grant%0d", i), 32'(s_g), i < 4 ? 0 : -1);
    end

    do_reset();
    for (int i = 0; i < 8; i++) cycle(1, mk(i % 2, 1, 1, 1, 1, 300 + i), 2'b00);
    for (int i = 0; i < 8; i++) begin
      cycle(0, '0, 2'b11);
      check($sformatf("rr_grant%0d", i), 32'(s_g), 32'(i % 2));
    end
    for (int i = 0; i < 8; i++) cycle(1, mk(i % 2, 1, 1, 1, 1, 400 + i), 2'b00);
    for (int i = 0; i < 4; i++) begin
      cycle(0, '0, 2'b01);
      check($sformatf("rr_block_grant%0d", i), 32'(s_g), 0);
    end
    for (int i = 0; i < 5; i++) cycle(0, '0, 2'b11);

    cycle(1, mk(0, 1, 0, 3, 1, 500), 2'b11);
    cycle(1, mk(0, 0, 0, 0, 0, 501), 2'b11);
    check("mid_head_sel", 32'(s_sel), 32'(5'b00100));
    do_reset();
    cycle(1, mk(0, 1, 1, 1, 2, 502), 2'b11);
    cycle(0, '0, 2'b11);
    check("post_rst_sel", 32'(s_sel), 32'(5'b00010));

    repeat (1500) begin
      rvc = $urandom_range(CH - 1);
      rlen = $urandom_range(1, 4);
      rv = $urandom_range(3) != 0;
      rf = gl[rvc] == 0 ? mk(rvc, 1, rlen == 1, $urandom_range(3), $urandom_range(3), $urandom)
                        : mk(rvc, 0, gl[rvc] == 1, $urandom_range(3), $urandom_range(3), $urandom);
      cycle(rv, rf, 2'($urandom));
      if (s_acc) gl[rvc] = gl[rvc] == 0 ? rlen - 1 : gl[rvc] - 1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
